// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sequential BRAM reader presenting words as a valid/ready stream; optional RD_STRIDE_EN adds stride_i
module bram_stream_reader #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int LWIDTH = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] base_i,
  input  logic [LWIDTH-1:0] len_i,
`ifdef RD_STRIDE_EN
  input  logic [AWIDTH-1:0] stride_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [AWIDTH-1:0] bram_addr_o,
  output logic              bram_ce_o,
  output logic              bram_we_o,
  input  logic [DWIDTH-1:0] bram_q_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [AWIDTH-1:0] r_addr, w_stride;
  logic [LWIDTH-1:0] r_idx, r_len;
  logic r_inflight, r_inflight_last;
  logic [DWIDTH-1:0] r_mem [2];
  logic [1:0] r_tag, r_count;
  logic r_rd, r_wr;
  logic w_pop, w_issue, w_final, w_start;
  logic [2:0] w_occ;
  assign w_start = (r_state == IDLE) && start_i;
  assign w_pop = valid_o & ready_i;
  assign w_occ = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = (r_state == READ) && (w_occ <= 3'd1);
  assign w_final = r_idx == r_len - 1'b1;
`ifdef RD_STRIDE_EN
  logic [AWIDTH-1:0] r_stride;
  // latch the stride alongside base and length
  always_ff @(posedge clk) begin
    if (rst) r_stride <= '0;
    else if (w_start) r_stride <= stride_i;
  end
  assign w_stride = r_stride;
`else
  assign w_stride = {{(AWIDTH-1){1'b0}}, 1'b1};
`endif
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: drain ends on the pop that empties the FIFO so done follows the last handshake directly
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start_i) w_next = (len_i == '0) ? DONE : READ;
      READ:  if (w_issue && w_final) w_next = DRAIN;
      DRAIN: if (!r_inflight && (r_count == 2'd0 || (r_count == 2'd1 && w_pop))) w_next = DONE;
      DONE:  w_next = IDLE;
    endcase
  end
  // FSM-derived outputs
  always_comb begin
    busy_o = r_state != IDLE;
    done_o = r_state == DONE;
    bram_ce_o = w_issue;
    bram_we_o = 1'b0;
    bram_addr_o = r_addr;
    valid_o = r_count != 2'd0;
    data_o = r_mem[r_rd];
    last_o = valid_o & r_tag[r_rd];
  end
  // address accumulator and word index; the address stays on the final issued word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_inflight <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_inflight_last <= w_issue & w_final;
      if (w_start) begin
        r_addr <= base_i;
        r_len <= len_i;
        r_idx <= '0;
      end else if (w_issue) begin
        r_idx <= r_idx + 1'b1;
        if (!w_final) r_addr <= r_addr + w_stride;
      end
    end
  end
  // 2-entry FIFO capturing BRAM data the cycle after each issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_tag <= '0;
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_count <= '0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wr] <= bram_q_i;
        r_tag[r_wr] <= r_inflight_last;
        r_wr <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end
endmodule
